// File: rtl/tc_ram_bank.sv
// tc_ram_bank: word-addressed single-port data RAM for the CPU datapath.
// Writes land on the rising edge. Reads are combinational and gated by load,
// so the output can sit directly on a shared data bus. Reset is synchronous
// and active-low, and it clears every word in one cycle.
module tc_ram_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  save,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Flop-based storage, so the whole array can be cleared in a single cycle.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    // Reset clears every word and takes priority over save. Otherwise a save
    // writes the addressed word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem <= '0;
        end else if (save) begin
            mem[address] <= in;
        end
    end

    // Bus-friendly read: the output is zero unless the RAM is loading and is
    // out of reset. It shows the pre-edge word, so a same-cycle save reads
    // the old value first.
    always_comb begin
        out = '0;
        if (rst && load) begin
            out = mem[address];
        end
    end

endmodule

// File: tb/tb_tc_ram_bank.sv
// Directed bench for tc_ram_bank. Each expected value is pushed to a
// scoreboard when it is decided. The value is popped and compared once the
// combinational read has settled.
module tb_tc_ram_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       save;
    logic [7:0] address;
    logic [7:0] din;
    logic [7:0] out;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] model[0:255];

    tc_ram_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .save    (save),
        .address (address),
        .in      (din),
        .out     (out)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Push the expectation, let the combinational read settle, then pop and compare.
    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        ntot++;
        assert (out === e) npass++;
        else $error("FAIL %s: out=%02h expected %02h", t, out, e);
    endtask

    // Write one word on the next edge and mirror it in the bench model.
    task automatic write(input logic [7:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        save    = 1'b1;
        tick();
        save    = 1'b0;
        model[a] = d;
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; save = 1'b1; address = 8'h00; din = 8'h5A;

        // Test 1: reset held for five clocks. The output is forced low even
        // while load is high.
        for (int i = 0; i < 5; i++) tick();
        check("out_in_reset", 8'h00);
        rst = 1'b1; save = 1'b0;
        for (int a = 0; a < 256; a++) model[a] = 8'h00;
        for (int a = 0; a < 256; a++) begin
            address = 8'(a);
            check($sformatf("sweep_%02h", a), 8'h00);
        end

        // Test 2: basic write, read, then read gated off.
        write(8'h00, 8'h01);
        load = 1'b1; address = 8'h00;
        check("t2_read", 8'h01);
        load = 1'b0;
        check("t2_load0", 8'h00);

        // Test 3: neighbouring address, no cross-talk.
        write(8'h01, 8'h02);
        load = 1'b1; address = 8'h01;
        check("t3_read01", 8'h02);
        address = 8'h00;
        check("t3_read00", 8'h01);

        // Test 4: read-before-write on the same address.
        load = 1'b1; save = 1'b1; address = 8'h05; din = 8'hA5;
        check("t4_before_edge", 8'h00);
        tick();
        save = 1'b0;
        model[8'h05] = 8'hA5;
        check("t4_after_edge", 8'hA5);

        // Test 5: reset pulse with a coincident save, which must be dropped.
        write(8'hFF, 8'hFF);
        write(8'h00, 8'h3C);
        address = 8'hFF;
        check("t5_pre_ff", 8'hFF);
        address = 8'h00;
        check("t5_pre_00", 8'h3C);
        rst = 1'b0; save = 1'b1; din = 8'h77; address = 8'hFF;
        check("t5_out_during_rst", 8'h00);
        tick();
        rst = 1'b1; save = 1'b0;
        for (int a = 0; a < 256; a++) model[a] = 8'h00;
        check("t5_post_ff", 8'h00);
        address = 8'h00;
        check("t5_post_00", 8'h00);
        address = 8'h05;
        check("t5_post_05", 8'h00);

        // Test 6: the last of back-to-back writes wins, and neighbours stay untouched.
        address = 8'h80; din = 8'h11; save = 1'b1;
        tick();
        din = 8'h22;
        tick();
        save = 1'b0;
        model[8'h80] = 8'h22;
        check("t6_last_wins", 8'h22);
        address = 8'h81;
        check("t6_neighbour", 8'h00);

        // Random writes checked against the bench model, then a full readback.
        for (int i = 0; i < 48; i++) write(8'($urandom_range(255)), 8'($urandom_range(255)));
        load = 1'b1;
        for (int a = 0; a < 256; a++) begin
            address = 8'(a);
            check($sformatf("rand_%02h", a), model[a]);
        end

        // load low blanks the bus whatever is stored.
        load = 1'b0;
        for (int a = 0; a < 256; a += 37) begin
            address = 8'(a);
            check($sformatf("load0_%02h", a), 8'h00);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
